store_pack_buffer: RTL and testbench

- Store-side counterpart of the immediate/load extension path in the MIPS datapath.
- Extension widens narrow data to 32 bits. This block narrows 32-bit register data for sw/sh/sb: it selects byte lanes, replicates the data, and generates byte enables.
- Packed stores are queued in a small FIFO and drained to data memory through a req/ack handshake, so the pipeline does not wait on memory.
- Sits between the MEM-stage store path and the data-memory port.

---
 rtl/store_pack_buffer.sv | 122 ++++++++++++
 tb/tb_store_pack_buffer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_pack_buffer.sv
// Store pack buffer: narrows sw/sh/sb data into byte-laned words and queues them toward memory.
// Optional STORE_HAZARD_EN adds a load-address hazard compare against all pending entries.
module store_pack_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [1:0]       st_op,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  output logic             mem_req,
  input  logic             mem_ack,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_be,
  output logic             buf_empty,
  output logic [PTR_W:0]   buf_count,
  output logic             addr_err
`ifdef STORE_HAZARD_EN
  ,
  input  logic [31:0]      ld_addr,
  output logic             ld_hazard
`endif
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             addr_err_q;

  logic [29:0] addr_mem [DEPTH];
  logic [31:0] data_mem [DEPTH];
  logic [3:0]  be_mem   [DEPTH];

  logic [31:0] pk_wdata;
  logic [3:0]  pk_be;
  logic        pk_err;
  logic        push, pop, handshake;

  always_comb begin
    pk_wdata = st_data;
    pk_be    = 4'b0000;
    pk_err   = 1'b0;
    case (st_op)
      2'b00: begin
        pk_be  = 4'b1111;
        pk_err = (st_addr[1:0] != 2'b00);
      end
      2'b01: begin
        pk_wdata = {st_data[15:0], st_data[15:0]};
        pk_be    = st_addr[1] ? 4'b1100 : 4'b0011;
        pk_err   = st_addr[0];
      end
      2'b10: begin
        pk_wdata = {4{st_data[7:0]}};
        pk_be    = 4'b0001 << st_addr[1:0];
      end
      default: pk_err = 1'b1;
    endcase
  end

  assign st_ready  = (count_q != FULL_CNT);
  assign buf_empty = (count_q == '0);
  assign buf_count = count_q;
  assign mem_req   = !buf_empty;
  assign addr_err  = addr_err_q;

  assign handshake = st_valid && st_ready;
  assign push      = handshake && !pk_err;
  assign pop       = mem_req && mem_ack;

  // Head outputs are forced to zero while empty so stale entries never leak out.
  assign mem_addr  = mem_req ? {addr_mem[rd_ptr_q], 2'b00} : '0;
  assign mem_wdata = mem_req ? data_mem[rd_ptr_q] : '0;
  assign mem_be    = mem_req ? be_mem[rd_ptr_q] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      addr_err_q <= 1'b0;
    end else begin
      addr_err_q <= handshake && pk_err;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage carries no reset; validity is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= st_addr[31:2];
      data_mem[wr_ptr_q] <= pk_wdata;
      be_mem[wr_ptr_q]   <= pk_be;
    end
  end

`ifdef STORE_HAZARD_EN
  logic [PTR_W-1:0] slot;

  always_comb begin
    ld_hazard = 1'b0;
    slot      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      // Distance from the head decides whether slot i currently holds a live entry.
      slot = PTR_W'(i) - rd_ptr_q;
      if (({1'b0, slot} < count_q) && (addr_mem[i] == ld_addr[31:2])) ld_hazard = 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_store_pack_buffer.sv
// Bench for store_pack_buffer: directed scenarios plus randomized traffic against a queue model.
// Define STORE_HAZARD_EN to also exercise the load hazard output.
module tb_store_pack_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [1:0]  st_op;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        buf_empty;
  logic [2:0]  buf_count;
  logic        addr_err;
  logic [31:0] ld_addr;
  logic        ld_hazard;

  int n_tests = 0;
  int n_fail  = 0;

  store_pack_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_op     (st_op),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .mem_req   (mem_req),
    .mem_ack   (mem_ack),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .buf_empty (buf_empty),
    .buf_count (buf_count),
    .addr_err  (addr_err)
`ifdef STORE_HAZARD_EN
    ,
    .ld_addr   (ld_addr),
    .ld_hazard (ld_hazard)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } ent_t;

  ent_t q[$];
  logic exp_err = 1'b0;

  function automatic logic illegal(input logic [1:0] op, input logic [31:0] a);
    return (op == 2'd3) || (op == 2'd0 && (a % 4) != 0) || (op == 2'd1 && (a % 2) != 0);
  endfunction

  function automatic ent_t pack(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    ent_t e;
    e.addr = a & ~32'd3;
    e.wdata = d;
    e.be = 4'hF;
    if (op == 2'd1) begin
      e.wdata = (d & 32'h0000FFFF) * 32'h00010001;
      e.be    = 4'(32'd3 << (a & 32'd2));
    end else if (op == 2'd2) begin
      e.wdata = (d & 32'h000000FF) * 32'h01010101;
      e.be    = 4'(32'd1 << (a % 4));
    end
    return e;
  endfunction

  function automatic logic [31:0] head_addr();
    return (q.size() != 0) ? q[0].addr : 32'h0;
  endfunction
  function automatic logic [31:0] head_wdata();
    return (q.size() != 0) ? q[0].wdata : 32'h0;
  endfunction
  function automatic logic [3:0] head_be();
    return (q.size() != 0) ? q[0].be : 4'h0;
  endfunction
  function automatic logic model_hazard(input logic [31:0] la);
    foreach (q[i]) if (q[i].addr[31:2] == la[31:2]) return 1'b1;
    return 1'b0;
  endfunction

  // Drive one cycle of inputs, advance past the edge, and update the model.
  task automatic cycle(input logic v, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] d, input logic ack);
    bit hs, bad, pp;
    st_valid = v; st_op = op; st_addr = a; st_data = d; mem_ack = ack;
    hs  = v && (q.size() != DEPTH);
    bad = illegal(op, a);
    pp  = (q.size() != 0) && ack;
    @(posedge clk); #1;
    if (pp) void'(q.pop_front());
    if (hs && !bad) q.push_back(pack(op, a, d));
    exp_err = hs && bad;
  endtask

  task automatic idle(input logic ack);
    cycle(1'b0, 2'd0, 32'h0, 32'h0, ack);
  endtask

  task automatic test_reset;
    reset = 1'b1; st_valid = 0; st_op = 0; st_addr = 0; st_data = 0; mem_ack = 0; ld_addr = 0;
    #12;
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b exp 0", mem_req); end
    n_tests++; if (buf_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d exp 0", buf_count); end
    n_tests++; if (buf_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b exp 1", buf_empty); end
    n_tests++; if (st_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b exp 1", st_ready); end
    n_tests++; if (addr_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b exp 0", addr_err); end
    n_tests++; if ({mem_addr, mem_wdata, mem_be} !== 68'h0) begin
      n_fail++; $display("FAIL reset_head: got %h/%h/%h exp 0", mem_addr, mem_wdata, mem_be);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    q.delete();
  endtask

  task automatic test_sw_basic;
    cycle(1'b1, 2'd0, 32'h100, 32'hDEADBEEF, 1'b1);
    n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL sw_req: got %b exp 1", mem_req); end
    n_tests++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL sw_addr: got %h exp 00000100", mem_addr); end
    n_tests++; if (mem_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_wdata: got %h exp deadbeef", mem_wdata); end
    n_tests++; if (mem_be !== 4'b1111) begin n_fail++; $display("FAIL sw_be: got %b exp 1111", mem_be); end
    idle(1'b1);
    n_tests++; if (buf_empty !== 1'b1) begin n_fail++; $display("FAIL sw_drained: got %b exp 1", buf_empty); end
  endtask

  task automatic test_sh_sb;
    cycle(1'b1, 2'd1, 32'h102, 32'h1234ABCD, 1'b0);
    n_tests++; if (mem_wdata !== 32'hABCDABCD) begin n_fail++; $display("FAIL sh_wdata: got %h exp abcdabcd", mem_wdata); end
    n_tests++; if (mem_be !== 4'b1100) begin n_fail++; $display("FAIL sh_be: got %b exp 1100", mem_be); end
    n_tests++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL sh_addr: got %h exp 00000100", mem_addr); end
    cycle(1'b1, 2'd2, 32'h203, 32'h00000055, 1'b1);
    n_tests++; if (mem_wdata !== 32'h55555555) begin n_fail++; $display("FAIL sb_wdata: got %h exp 55555555", mem_wdata); end
    n_tests++; if (mem_be !== 4'b1000) begin n_fail++; $display("FAIL sb_be: got %b exp 1000", mem_be); end
    n_tests++; if (mem_addr !== 32'h200) begin n_fail++; $display("FAIL sb_addr: got %h exp 00000200", mem_addr); end
    idle(1'b1);
  endtask

  task automatic test_fill_stall_drain;
    logic [31:0] a0, w0;
    logic [3:0]  b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) begin
        n_tests++; if (st_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b exp 0", st_ready); end
      end
      cycle(1'b1, 2'd0, 32'h400 + 32'(4 * k), $urandom, 1'b0);
    end
    n_tests++; if (buf_count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d exp 4", buf_count); end
    n_tests++; if (addr_err !== 1'b0) begin n_fail++; $display("FAIL full_noerr: got %b exp 0", addr_err); end
    a0 = mem_addr; w0 = mem_wdata; b0 = mem_be;
    for (int k = 0; k < 3; k++) begin
      idle(1'b0);
      n_tests++; if ({mem_req, mem_addr, mem_wdata, mem_be} !== {1'b1, q[0].addr, q[0].wdata, q[0].be}
                     || {mem_addr, mem_wdata, mem_be} !== {a0, w0, b0}) begin
        n_fail++; $display("FAIL stall_hold: got %h/%h/%h exp %h/%h/%h",
                           mem_addr, mem_wdata, mem_be, q[0].addr, q[0].wdata, q[0].be);
      end
    end
    for (int k = 0; k < 4; k++) begin
      idle(1'b1);
      n_tests++; if (buf_count !== 3'(q.size()) || mem_req !== (q.size() != 0)
                     || mem_addr !== head_addr() || mem_wdata !== head_wdata()) begin
        n_fail++; $display("FAIL drain_order: got cnt %0d addr %h wd %h exp cnt %0d addr %h wd %h",
                           buf_count, mem_addr, mem_wdata, q.size(), head_addr(), head_wdata());
      end
    end
  endtask

  task automatic test_errors;
    logic [1:0]  ops [3] = '{2'd0, 2'd1, 2'd3};
    logic [31:0] adr [3] = '{32'h101, 32'h103, 32'h100};
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, ops[k], adr[k], $urandom, 1'b0);
      n_tests++; if (addr_err !== 1'b1 || buf_count !== 3'd0) begin
        n_fail++; $display("FAIL err_pulse%0d: got err %b cnt %0d exp err 1 cnt 0", k, addr_err, buf_count);
      end
      idle(1'b0);
      n_tests++; if (addr_err !== 1'b0) begin
        n_fail++; $display("FAIL err_oneshot%0d: got %b exp 0", k, addr_err);
      end
    end
  endtask

  task automatic test_simul_and_reset;
    cycle(1'b1, 2'd0, 32'h500, 32'h11111111, 1'b0);
    cycle(1'b1, 2'd0, 32'h504, 32'h22222222, 1'b0);
    cycle(1'b1, 2'd0, 32'h508, 32'h33333333, 1'b1);
    n_tests++; if (buf_count !== 3'd2 || mem_addr !== 32'h504 || mem_wdata !== 32'h22222222) begin
      n_fail++; $display("FAIL simul: got cnt %0d addr %h wd %h exp cnt 2 addr 00000504 wd 22222222",
                         buf_count, mem_addr, mem_wdata);
    end
    idle(1'b1);
    reset = 1'b1;
    #1;
    n_tests++; if (mem_req !== 1'b0 || buf_count !== 3'd0 || buf_empty !== 1'b1) begin
      n_fail++; $display("FAIL async_reset: got req %b cnt %0d exp req 0 cnt 0", mem_req, buf_count);
    end
    q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_hazard;
`ifdef STORE_HAZARD_EN
    cycle(1'b1, 2'd0, 32'h300, 32'hCAFEF00D, 1'b0);
    ld_addr = 32'h302; #1;
    n_tests++; if (ld_hazard !== 1'b1) begin n_fail++; $display("FAIL hz_hit: got %b exp 1", ld_hazard); end
    ld_addr = 32'h304; #1;
    n_tests++; if (ld_hazard !== 1'b0) begin n_fail++; $display("FAIL hz_miss: got %b exp 0", ld_hazard); end
    ld_addr = 32'h302;
    idle(1'b1);
    n_tests++; if (ld_hazard !== 1'b0) begin n_fail++; $display("FAIL hz_drained: got %b exp 0", ld_hazard); end
`endif
  endtask

  task automatic test_random;
    logic [31:0] a;
    for (int k = 0; k < 400; k++) begin
      a = 32'h1000 + 32'($urandom_range(0, 7) * 4);
      if ($urandom_range(0, 1) == 0) a = a + 32'($urandom_range(0, 3));
      ld_addr = 32'h1000 + 32'($urandom_range(0, 31));
      cycle(($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)), a, $urandom,
            ($urandom_range(0, 9) < 4));
      n_tests++; if (buf_count !== 3'(q.size()) || buf_empty !== (q.size() == 0)
                     || mem_req !== (q.size() != 0) || st_ready !== (q.size() != DEPTH)) begin
        n_fail++; $display("FAIL rnd_state @%0d: got cnt %0d req %b rdy %b exp cnt %0d", k,
                           buf_count, mem_req, st_ready, q.size());
      end
      n_tests++; if (mem_addr !== head_addr() || mem_wdata !== head_wdata() || mem_be !== head_be()) begin
        n_fail++; $display("FAIL rnd_head @%0d: got %h/%h/%h exp %h/%h/%h", k, mem_addr, mem_wdata,
                           mem_be, head_addr(), head_wdata(), head_be());
      end
      n_tests++; if (addr_err !== exp_err) begin
        n_fail++; $display("FAIL rnd_err @%0d: got %b exp %b", k, addr_err, exp_err);
      end
`ifdef STORE_HAZARD_EN
      n_tests++; if (ld_hazard !== model_hazard(ld_addr)) begin
        n_fail++; $display("FAIL rnd_hazard @%0d: got %b exp %b", k, ld_hazard, model_hazard(ld_addr));
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_sw_basic();
    test_sh_sb();
    test_fill_stall_drain();
    test_errors();
    test_simul_and_reset();
    test_hazard();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
